// File: rtl/rx_chain_multi_pkg.sv
// Shared definitions for the multi-channel RX decimation chain.
// Optional build macro RX_CHAIN_MULTI_SAT_EN adds the saturating adder.
package rx_chain_multi_pkg;

    // Position of each component inside a packed {Q, I} word, in field units
    localparam int I_FIELD = 0;
    localparam int Q_FIELD = 1;

    // Default widths used by the packed views below
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 32;

    typedef struct packed {
        logic signed [DEF_DATA_W-1:0] q;
        logic signed [DEF_DATA_W-1:0] i;
    } iq_sample_t;

    typedef struct packed {
        logic signed [DEF_ACC_W-1:0] q;
        logic signed [DEF_ACC_W-1:0] i;
    } iq_sum_t;

`ifdef RX_CHAIN_MULTI_SAT_EN
    // Add two sign-extended operands and clamp the result to a w-bit signed range
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int unsigned        w);
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        s  = {a[63], a} + {b[63], b};
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -hi - 65'sd1;
        if (s > hi)
            return hi[63:0];
        else if (s < lo)
            return lo[63:0];
        else
            return s[63:0];
    endfunction
`endif

endpackage

// File: rtl/rx_chain_multi_model_channel.sv
// One RX channel: accumulate-and-dump decimator, FWFT FIFO, AXI-stream output.
// Build macro RX_CHAIN_MULTI_SAT_EN selects saturating instead of wrapping sums.
module rx_decim_channel
    import rx_chain_multi_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ACC_W      = 32,
    parameter int RATE_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [RATE_W-1:0]             rate,
    input  logic                          rate_vld,
    input  logic [2*DATA_W-1:0]           iq,
    input  logic                          iq_vld,
    input  logic                          tready,
    output logic                          tvalid,
    output logic [2*ACC_W-1:0]            tdata,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state_q, state_d;
    logic [RATE_W-1:0]        rate_q;
    logic [RATE_W-1:0]        cnt_p0;
    logic signed [ACC_W-1:0]  acc_i_p0, acc_q_p0;
    logic signed [ACC_W-1:0]  sum_i, sum_q;
    logic signed [DATA_W-1:0] smp_i, smp_q;
    logic                     take, dump, pop, full, push_ok;
    logic [2*ACC_W-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [AW:0]              level_q;
    logic                     overflow_q;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] x);
        return {{(ACC_W-DATA_W){x[DATA_W-1]}}, x};
    endfunction

    function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
`ifdef RX_CHAIN_MULTI_SAT_EN
        logic signed [63:0] r;
        r = sat_add({{(64-ACC_W){a[ACC_W-1]}}, a}, {{(64-ACC_W){b[ACC_W-1]}}, b}, ACC_W);
        return r[ACC_W-1:0];
`else
        return a + b;
`endif
    endfunction

    assign smp_i = iq[I_FIELD*DATA_W +: DATA_W];
    assign smp_q = iq[Q_FIELD*DATA_W +: DATA_W];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state, sample acceptance and dump decision; a rate write always wins
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        dump    = 1'b0;
        sum_i   = acc_add(acc_i_p0, sext(smp_i));
        sum_q   = acc_add(acc_q_p0, sext(smp_q));
        case (state_q)
            IDLE: begin
                if (rate_vld && rate != '0)
                    state_d = RUN;
            end
            RUN: begin
                if (rate_vld) begin
                    if (rate == '0)
                        state_d = IDLE;
                end else if (iq_vld) begin
                    take = 1'b1;
                    dump = (cnt_p0 == rate_q - RATE_W'(1));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Rate register, accumulators and sample counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_q   <= '0;
            cnt_p0   <= '0;
            acc_i_p0 <= '0;
            acc_q_p0 <= '0;
        end else if (rate_vld) begin
            rate_q   <= rate;
            cnt_p0   <= '0;
            acc_i_p0 <= '0;
            acc_q_p0 <= '0;
        end else if (take) begin
            if (dump) begin
                cnt_p0   <= '0;
                acc_i_p0 <= '0;
                acc_q_p0 <= '0;
            end else begin
                cnt_p0   <= cnt_p0 + RATE_W'(1);
                acc_i_p0 <= sum_i;
                acc_q_p0 <= sum_q;
            end
        end
    end

    // ---- FIFO stage ----
    assign tvalid  = (level_q != '0);
    assign pop     = tvalid && tready;
    assign full    = (level_q == (AW+1)'(FIFO_DEPTH));
    assign push_ok = dump && (!full || pop);
    assign tdata   = tvalid ? mem[rd_ptr] : '0;
    assign level   = level_q;
    assign overflow = overflow_q;

    // FIFO storage; contents are masked by tvalid so no reset is needed
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= {sum_q, sum_i};
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
            if (rate_vld)
                overflow_q <= 1'b0;
            else if (dump && full && !pop)
                overflow_q <= 1'b1;
        end
    end

endmodule

// File: rtl/rx_chain_multi_model.sv
// N-channel RX decimation chain feeding marga's RX AXI-stream inputs.
// Build macro RX_CHAIN_MULTI_SAT_EN selects saturating instead of wrapping sums.
module rx_chain_multi_model
    import rx_chain_multi_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int DATA_W     = 16,
    parameter int ACC_W      = 32,
    parameter int RATE_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NCH*RATE_W-1:0]                  rate_axis_tdata_i,
    input  logic [NCH-1:0]                         rate_axis_tvalid_i,
    input  logic [NCH*2*DATA_W-1:0]                rx_iq_axis_tdata_i,
    input  logic [NCH-1:0]                         rx_iq_axis_tvalid_i,
    input  logic [NCH-1:0]                         axis_tready_i,
    output logic [NCH-1:0]                         axis_tvalid_o,
    output logic [NCH*2*ACC_W-1:0]                 axis_tdata_o,
    output logic [NCH-1:0]                         overflow_o,
    output logic [NCH*($clog2(FIFO_DEPTH)+1)-1:0]  fifo_level_o
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        rx_decim_channel #(
            .DATA_W     (DATA_W),
            .ACC_W      (ACC_W),
            .RATE_W     (RATE_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .rate     (rate_axis_tdata_i[c*RATE_W +: RATE_W]),
            .rate_vld (rate_axis_tvalid_i[c]),
            .iq       (rx_iq_axis_tdata_i[c*2*DATA_W +: 2*DATA_W]),
            .iq_vld   (rx_iq_axis_tvalid_i[c]),
            .tready   (axis_tready_i[c]),
            .tvalid   (axis_tvalid_o[c]),
            .tdata    (axis_tdata_o[c*2*ACC_W +: 2*ACC_W]),
            .overflow (overflow_o[c]),
            .level    (fifo_level_o[c*LVL_W +: LVL_W])
        );
    end

endmodule

// File: doc/rx_chain_multi_model.md
Name: rx_chain_multi_model

Overview:
- Parametrised N-channel successor to the single-channel RX chain model used in the marga top-level simulation.
- Each channel does the following:
  - Takes a 32-bit I/Q AXI-stream from the TX/DDS side.
  - Decimates by a runtime rate using accumulate-and-dump.
  - Buffers results in a per-channel FIFO.
  - Presents 64-bit words to marga's RX AXI-stream inputs with full tready backpressure and sticky overflow reporting.

Parameters:
- NCH, 2, number of independent RX channels
- DATA_W, 16, signed I and Q sample width
- ACC_W, 32, signed accumulator and output width per component
- RATE_W, 16, decimation-rate field width
- FIFO_DEPTH, 16, words per channel FIFO; power of two, >=2

Ports:
- clk  in  1  single clock for all channels
- rst_n  in  1  reset, asynchronous assert, active-low
- rate_axis_tdata_i  in  NCH*RATE_W  per-channel decimation rate; channel c in bits [c*RATE_W +: RATE_W]
- rate_axis_tvalid_i  in  NCH  rate write strobe per channel
- rx_iq_axis_tdata_i  in  NCH*2*DATA_W  per channel: {Q, I}, I in low half
- rx_iq_axis_tvalid_i  in  NCH  input sample valid; always accepted, no tready
- axis_tready_i  in  NCH  downstream ready per channel
- axis_tvalid_o  out  NCH  output word valid
- axis_tdata_o  out  NCH*2*ACC_W  per channel: {Q_sum, I_sum}, I in low half
- overflow_o  out  NCH  sticky: a dump was lost because the FIFO was full
- fifo_level_o  out  NCH*($clog2(FIFO_DEPTH)+1)  current FIFO occupancy per channel

Behaviour:
- Channels are fully independent. Everything below is per channel.
- Reset, asynchronous on rst_n low:
  - Rate register = 0; accumulators and count = 0.
  - FIFO empty; axis_tvalid_o = 0, axis_tdata_o = 0, overflow_o = 0, fifo_level_o = 0.
- States:
  - IDLE (rate==0): input samples are ignored. A rate write with value !=0 moves the channel to RUN on the next cycle.
  - RUN: each valid sample is sign-extended to ACC_W and added to acc_i/acc_q; count increments.
  - On the sample where count==rate-1, a dump occurs:
    - The push word is {acc_q+Q, acc_i+I}.
    - Accumulators and count go to 0 in the same cycle. There is no dead cycle; the next sample starts a new sum.
  - rate==1 passes every sample through, sign-extended.
- Rate write (rate_axis_tvalid_i high):
  - Loads the new rate; clears accumulators, count and overflow_o.
  - Any sample presented in the same cycle is discarded.
  - A write of 0 returns the channel to IDLE. Words already in the FIFO are retained and still drain.
- Arithmetic: two's-complement, wraps modulo 2^ACC_W (see Optional Feature).
- FIFO:
  - Synchronous, first-word-fall-through from registered storage.
  - The pushed word appears on axis_tvalid_o/axis_tdata_o on the cycle after the dump edge when the FIFO was empty.
- Output handshake:
  - A pop occurs when axis_tvalid_o && axis_tready_i.
  - axis_tdata_o is held stable while tvalid && !tready.
  - axis_tdata_o = 0 when tvalid = 0.
- Push when full:
  - If a pop happens in the same cycle, the push is accepted and the level is unchanged.
  - Otherwise the word is dropped and overflow_o is set. overflow_o stays high until reset or a rate write.
- fifo_level_o updates on the same edge as the push or pop.

Optional Feature:
- Macro RX_CHAIN_MULTI_SAT_EN.
- Defined: accumulators saturate at +2^(ACC_W-1)-1 / -2^(ACC_W-1) instead of wrapping. Saturation is evaluated per add, and the saturated value is what gets dumped.
- Undefined: plain modulo wrap. No extra logic is generated.

Decomposition:
- Package rx_chain_multi_pkg holds:
  - localparams for field offsets.
  - typedef iq_sample_t (packed signed I/Q, DATA_W).
  - typedef iq_sum_t (packed signed I/Q, ACC_W).
  - Saturating-add function, guarded by RX_CHAIN_MULTI_SAT_EN.
- One sub-module, rx_decim_channel, contains the accumulator FSM, FIFO and handshake. The top uses a generate loop over NCH plus port slicing.

Test Plan:
1. Reset, then write rate=4 to ch0, then feed I=1, Q=-1 for 8 cycles -> two words {Q=-4, I=4} (64'hFFFFFFFC_00000004). The first word appears 1 cycle after the 4th sample edge. Ch1 stays tvalid=0.
2. rate=1 on ch1, 5 samples I=0x8000 (-32768) -> 5 words each with I_sum=0xFFFF8000 (sign-extended), back-to-back tvalid.
3. rate=1, tready held 0, 17 samples with FIFO_DEPTH=16 -> fifo_level_o=16, overflow_o=1 after the 17th. The first 16 words drain in order when tready rises. A subsequent rate write clears overflow_o.
4. rate=4, after 2 samples write rate=2 with a sample in the same cycle -> that sample and the partial sum are discarded; the next word is the sum of the following 2 samples.
5. Assert rst_n low for 1 cycle mid-accumulation with 3 words in the FIFO -> all outputs 0 immediately (asynchronous); rate=0 after release; samples are ignored.
6. With RX_CHAIN_MULTI_SAT_EN and ACC_W=18, rate=8, I=0x7FFF for 8 samples -> I_sum=0x1FFFF (saturated). Without the macro -> wrapped value 0x3FFF8.
